// File: rtl/mem_arbiter_rr_if.sv
// Bus bundle between N requesting masters, the arbiter and the single slave port.
// The "master" modport is the outside world (masters plus the memory/slave model);
// the "slave" modport is the arbiter itself.
interface mem_arbiter_rr_if #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64
) ();

  // master-facing side
  logic [N_MASTERS-1:0]        m_req;
  logic [N_MASTERS*ADDR_W-1:0] m_addr;
  logic [N_MASTERS-1:0]        m_write;
  logic [N_MASTERS*DATA_W-1:0] m_wdata;
  logic [N_MASTERS-1:0]        m_done;
  logic [N_MASTERS-1:0]        m_stall;
  logic [DATA_W-1:0]           m_rdata;

  // slave-facing side
  logic                        s_valid;
  logic [ADDR_W-1:0]           s_addr;
  logic                        s_write;
  logic [DATA_W-1:0]           s_wdata;
  logic                        s_ready;
  logic [DATA_W-1:0]           s_rdata;

  modport master (
    output m_req, m_addr, m_write, m_wdata, s_ready, s_rdata,
    input  m_done, m_stall, m_rdata, s_valid, s_addr, s_write, s_wdata
  );

  modport slave (
    input  m_req, m_addr, m_write, m_wdata, s_ready, s_rdata,
    output m_done, m_stall, m_rdata, s_valid, s_addr, s_write, s_wdata
  );

endinterface

// File: rtl/mem_arbiter_rr.sv
// N-master memory-bus arbiter: picks one requester (fixed priority or round-robin),
// latches its address/write flag/write data, runs one slave transaction with a
// ready handshake and returns read data alongside a one-cycle one-hot done pulse.
module mem_arbiter_rr #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int RR_MODE   = 1
) (
  input  logic            CLK,
  input  logic            RESET,
  mem_arbiter_rr_if.slave bus
);

  localparam int PTR_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [PTR_W-1:0]       win_q, win_d;
  logic                   s_valid_q, s_valid_d;
  logic [ADDR_W-1:0]      s_addr_q, s_addr_d;
  logic                   s_write_q, s_write_d;
  logic [DATA_W-1:0]      s_wdata_q, s_wdata_d;
  logic [DATA_W-1:0]      m_rdata_q, m_rdata_d;
  logic [N_MASTERS-1:0]   m_done_q, m_done_d;

  // Per-master views of the packed address / write-data buses
  logic [ADDR_W-1:0]      addr_arr  [N_MASTERS];
  logic [DATA_W-1:0]      wdata_arr [N_MASTERS];
  // Bit i set when master i sits at or above the round-robin pointer
  logic [N_MASTERS-1:0]   hi_mask;
  logic [N_MASTERS-1:0]   req_hi;
  logic [PTR_W-1:0]       pick;

  genvar gi;
  generate
    for (gi = 0; gi < N_MASTERS; gi++) begin : g_unpack
      assign addr_arr[gi]  = bus.m_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = bus.m_wdata[gi*DATA_W +: DATA_W];
      assign hi_mask[gi]   = (PTR_W'(gi) >= ptr_q);
    end
  endgenerate

  // Index of the lowest set bit; only meaningful when v is nonzero
  function automatic logic [PTR_W-1:0] lowest_set(input logic [N_MASTERS-1:0] v);
    logic [PTR_W-1:0] r;
    r = '0;
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      if (v[i]) r = PTR_W'(i);
    end
    return r;
  endfunction

  assign req_hi = bus.m_req & hi_mask;

  // Winner selection: lowest index, or first requester at/after ptr with wrap-around
  always_comb begin
    pick = lowest_set(bus.m_req);
    if (RR_MODE != 0 && req_hi != '0) begin
      pick = lowest_set(req_hi);
    end
  end

  // Next-state and datapath logic for the IDLE -> BUSY -> RESP cycle
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    s_valid_d = s_valid_q;
    s_addr_d  = s_addr_q;
    s_write_d = s_write_q;
    s_wdata_d = s_wdata_q;
    m_rdata_d = m_rdata_q;
    m_done_d  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.m_req != '0) begin
          win_d     = pick;
          s_addr_d  = addr_arr[pick];
          s_write_d = bus.m_write[pick];
          s_wdata_d = wdata_arr[pick];
          s_valid_d = 1'b1;
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (bus.s_ready) begin
          m_rdata_d = bus.s_rdata;
          m_done_d  = N_MASTERS'(1) << win_q;
          s_valid_d = 1'b0;
          ptr_d     = (win_q == PTR_W'(N_MASTERS - 1)) ? '0 : win_q + PTR_W'(1);
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        s_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      s_valid_q <= 1'b0;
      s_addr_q  <= '0;
      s_write_q <= 1'b0;
      s_wdata_q <= '0;
      m_rdata_q <= '0;
      m_done_q  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      s_valid_q <= s_valid_d;
      s_addr_q  <= s_addr_d;
      s_write_q <= s_write_d;
      s_wdata_q <= s_wdata_d;
      m_rdata_q <= m_rdata_d;
      m_done_q  <= m_done_d;
    end
  end

  assign bus.s_valid = s_valid_q;
  assign bus.s_addr  = s_addr_q;
  assign bus.s_write = s_write_q;
  assign bus.s_wdata = s_wdata_q;
  assign bus.m_rdata = m_rdata_q;
  assign bus.m_done  = m_done_q;
  assign bus.m_stall = bus.m_req & ~m_done_q;

endmodule
